// File: rtl/conv_output_streamer_pkg.sv
// Shared sizing helpers and state encoding for the conv output streamer and its companions.
package conv_output_streamer_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } stream_state_e;

  // Spatial output size of a conv layer: (in + 2p - k) / s + 1.
  function automatic int out_dim(input int in_dim, input int k, input int s, input int p);
    return (in_dim + 2 * p - k) / s + 1;
  endfunction

  function automatic int num_words(input int b, input int c, input int h, input int w);
    return b * c * h * w;
  endfunction

  // Index width never collapses to zero, so a single-word tensor still has a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_output_streamer_word_counter.sv
// Word index counter with synchronous clear (priority), enable and terminal-count flag.
module stream_word_counter #(
  parameter int WIDTH = 11,
  parameter int MAX   = 1567
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= count + WIDTH'(1);
  end

  assign at_max = (count == WIDTH'(MAX));

endmodule

// File: rtl/conv_output_streamer.sv
// Snapshots the flat conv output tensor on start and streams it word by word over valid/ready.
module conv_output_streamer
  import conv_output_streamer_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int BATCH_SIZE   = 1,
  parameter int OUT_CHANNELS = 32,
  parameter int OUT_HEIGHT   = 7,
  parameter int OUT_WIDTH    = 7,
  localparam int NUM_WORDS   = num_words(BATCH_SIZE, OUT_CHANNELS, OUT_HEIGHT, OUT_WIDTH),
  localparam int IDX_W       = idx_width(NUM_WORDS)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [NUM_WORDS*DATA_WIDTH-1:0] tensor_flat,
  output logic                            busy,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [DATA_WIDTH-1:0]           m_data,
  output logic [IDX_W-1:0]                m_index,
  output logic                            m_last,
  output logic                            done
);

  stream_state_e                   state;
  logic [NUM_WORDS*DATA_WIDTH-1:0] snap;
  logic                            hs;
  logic                            at_max;

  assign hs = m_valid & m_ready;

  // The counter sits at zero whenever the streamer is idle, so start needs no explicit clear.
  stream_word_counter #(
    .WIDTH (IDX_W),
    .MAX   (NUM_WORDS - 1)
  ) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (hs & at_max),
    .en     (hs & ~at_max),
    .count  (m_index),
    .at_max (at_max)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      m_valid <= 1'b0;
      done    <= 1'b0;
      snap    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          snap    <= tensor_flat;
          state   <= ST_STREAM;
          busy    <= 1'b1;
          m_valid <= 1'b1;
        end
        ST_STREAM: if (hs && at_max) begin
          state   <= ST_IDLE;
          busy    <= 1'b0;
          m_valid <= 1'b0;
          done    <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Word select straight out of the snapshot; the index alone moves the window.
  always_comb begin
    int base;
    base   = int'(m_index) * DATA_WIDTH;
    m_data = snap[base +: DATA_WIDTH];
  end

  // Gated by valid so a single-word config does not flag last while idle.
  assign m_last = m_valid & at_max;

endmodule

// File: tb/tb_conv_output_streamer.sv
// Directed bench for conv_output_streamer: frame-level model checked every cycle plus literal pins.
module tb_conv_output_streamer;

  localparam int NW = 1568;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start, m_ready;
  logic [NW*DW-1:0]  tensor;
  logic              busy, m_valid, m_last, done;
  logic [DW-1:0]     m_data;
  logic [10:0]       m_index;

  logic              s_start, s_ready;
  logic [DW-1:0]     s_tensor;
  logic              s_busy, s_valid, s_last, s_done;
  logic [DW-1:0]     s_data;
  logic [0:0]        s_index;

  int checks   = 0;
  int failures = 0;
  int frames   = 0;

  always #5 clk = ~clk;

  conv_output_streamer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tensor_flat(tensor), .busy(busy),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_index(m_index),
    .m_last(m_last), .done(done)
  );

  conv_output_streamer #(.OUT_CHANNELS(1), .OUT_HEIGHT(1), .OUT_WIDTH(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(s_start), .tensor_flat(s_tensor), .busy(s_busy),
    .m_valid(s_valid), .m_ready(s_ready), .m_data(s_data), .m_index(s_index),
    .m_last(s_last), .done(s_done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Frame-level model: a captured word list and the position the sink has reached in it.
  logic [DW-1:0] frame [NW];
  bit            mdl_act = 1'b0;
  int            mdl_pos = 0;

  always @(negedge clk) begin
    bit exp_done;
    exp_done = 1'b0;
    if (!rst_n) begin
      mdl_act = 1'b0;
      mdl_pos = 0;
      chk("rst_valid", m_valid, 0);
      chk("rst_busy",  busy,    0);
      chk("rst_done",  done,    0);
      chk("rst_last",  m_last,  0);
      chk("rst_index", m_index, 0);
    end else begin
      // Inputs visible now are the ones sampled at the edge just past.
      if (mdl_act) begin
        if (m_ready) begin
          if (mdl_pos == NW - 1) begin
            mdl_act  = 1'b0;
            mdl_pos  = 0;
            exp_done = 1'b1;
            frames++;
          end else begin
            mdl_pos++;
          end
        end
      end else if (start) begin
        mdl_act = 1'b1;
        mdl_pos = 0;
        for (int i = 0; i < NW; i++) frame[i] = tensor[i*DW +: DW];
      end
      chk("mdl_valid", m_valid, mdl_act);
      chk("mdl_busy",  busy,    mdl_act);
      chk("mdl_done",  done,    exp_done);
      chk("mdl_index", m_index, mdl_pos);
      chk("mdl_last",  m_last,  mdl_act && (mdl_pos == NW - 1));
      if (mdl_act) chk("mdl_data", m_data, frame[mdl_pos]);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic run_frame(input bit rnd, input string nm);
    int n;
    n = 0;
    while (!done && n < 8000) begin
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    chk(nm, done, 1);
    m_ready = 1'b1;
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < NW; i++) tensor[i*DW +: DW] = 32'hA000_0000 + 32'(i);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; m_ready = 1'b0;
    s_start = 1'b0; s_ready = 1'b0; s_tensor = 32'h1234_5678;
    fill_ramp();
    tick(); tick();
    chk("init_data", m_data, 0);
    chk("init_s_last", s_last, 0);
    rst_n = 1'b1;
    tick();

    // Reset mid-stream at word 10, then restart.
    start = 1'b1; m_ready = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (m_index != 11'd10 && n < 100) begin tick(); n++; end
    chk("t1_reach10", m_index, 10);
    rst_n = 1'b0; #1;
    chk("t1_valid0", m_valid, 0);
    chk("t1_busy0",  busy,    0);
    chk("t1_index0", m_index, 0);
    chk("t1_data0",  m_data,  0);
    chk("t1_last0",  m_last,  0);
    tick(); rst_n = 1'b1; tick(); tick();
    chk("t1_no_done", done, 0);
    start = 1'b1; tick(); start = 1'b0;
    chk("t1_restart_valid", m_valid, 1);
    chk("t1_restart_index", m_index, 0);
    run_frame(1'b0, "t1_done");
    tick();

    // Full stream at full rate.
    start = 1'b1; m_ready = 1'b1; tick(); start = 1'b0;
    chk("t2_first_valid", m_valid, 1);
    chk("t2_first_data",  m_data,  32'hA000_0000);
    chk("t2_first_busy",  busy,    1);
    repeat (5) tick();
    chk("t2_idx5",  m_index, 5);
    chk("t2_data5", m_data,  32'hA000_0005);
    n = 0;
    while (!m_last && n < 2000) begin tick(); n++; end
    chk("t2_last_idx",  m_index, 1567);
    chk("t2_last_data", m_data,  32'hA000_061F);
    tick();
    chk("t2_done",  done,    1);
    chk("t2_busy",  busy,    0);
    chk("t2_valid", m_valid, 0);
    tick();
    chk("t2_done_pulse", done, 0);

    // Random backpressure.
    start = 1'b1; tick(); start = 1'b0;
    run_frame(1'b1, "t3_done");
    tick();

    // Snapshot isolation.
    start = 1'b1; m_ready = 1'b0; tick(); start = 1'b0;
    for (int i = 0; i < NW; i++) tensor[i*DW +: DW] = 32'hDEAD_BEEF;
    tick(); m_ready = 1'b1; tick(); tick();
    chk("t4_data2", m_data, 32'hA000_0002);
    run_frame(1'b0, "t4_done");
    fill_ramp();
    tick();

    // Start while busy and on the final handshake is ignored; start on done is taken.
    start = 1'b1; tick();
    repeat (3) tick();
    chk("t5_busy_ignored", m_index, 3);
    start = 1'b0;
    n = 0;
    while (!m_last && n < 2000) begin tick(); n++; end
    start = 1'b1; tick();
    chk("t5_done",  done,    1);
    chk("t5_valid", m_valid, 0);
    tick(); start = 1'b0;
    chk("t5_b2b_valid", m_valid, 1);
    chk("t5_b2b_index", m_index, 0);
    chk("t5_b2b_done",  done,    0);
    run_frame(1'b0, "t5_done2");
    tick();
    chk("frames", frames, 6);

    // Single-word configuration.
    s_start = 1'b1; tick(); s_start = 1'b0;
    chk("t6_valid", s_valid, 1);
    chk("t6_last",  s_last,  1);
    chk("t6_index", s_index, 0);
    chk("t6_data",  s_data,  32'h1234_5678);
    tick();
    chk("t6_stall_data", s_data, 32'h1234_5678);
    s_ready = 1'b1; tick();
    chk("t6_done",  s_done,  1);
    chk("t6_valid0", s_valid, 0);
    chk("t6_busy0", s_busy,  0);
    tick();
    chk("t6_done_pulse", s_done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
